// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding
// and the default operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used once per cycle by the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one result bit per clock, LSB first, WIDTH cycles
// per operation. Optional signed-overflow output under SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif
    logic             fa_s;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start exactly like IDLE so operations can run back to back.
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    part_d  = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                part_d  = WIDTH'({fa_s, part_q} >> 1);
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Final bit: publish the shifted-in result together with this cycle's carry.
                    sum_d   = WIDTH'({fa_s, part_q} >> 1);
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random
// operands against an arithmetic reference model. Honors SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         overflow;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_sum;
    logic         exp_c;
    logic         exp_o;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_result(input string tag);
        chk({tag, ".sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, ".carry"}, 32'(carry_out), 32'(exp_c));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, ".ovf"}, 32'(overflow), 32'(exp_o));
`endif
    endtask

    // Reference: exact integer sum, then signed overflow from operand/result signs.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W:0] full;
        full    = {1'b0, av} + {1'b0, bv};
        exp_sum = full[W-1:0];
        exp_c   = full[W];
        exp_o   = (av[W-1] == bv[W-1]) && (exp_sum[W-1] != av[W-1]);
    endtask

    task automatic apply_start(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
    endtask

    // Start is already pending; walk the operation edge by edge.
    // With hold set, start stays high and a/b are scrambled while RUN lasts.
    task automatic follow(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit hold);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        chk({tag, ".busy1"}, 32'(busy), 32'd1);
        chk({tag, ".done1"}, 32'(done), 32'd0);
        chk_result({tag, ".held1"});
        for (int k = 2; k <= W; k++) begin
            @(negedge clk);
            if (hold) begin
                a     = W'($urandom);
                b     = W'($urandom);
                start = (k != W);
            end
            @(posedge clk);
            #1;
            chk({tag, ".done_run"}, 32'(done), 32'd0);
            chk({tag, ".busy_run"}, 32'(busy), 32'd1);
            chk_result({tag, ".held_run"});
        end
        model(av, bv);
        @(posedge clk);
        #1;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        chk_result(tag);
    endtask

    task automatic expect_idle(input string tag);
        @(posedge clk);
        #1;
        chk({tag, ".idle_done"}, 32'(done), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk_result({tag, ".idle"});
    endtask

    initial begin
        int done_seen;
        logic [W-1:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        exp_sum = '0;
        exp_c   = 1'b0;
        exp_o   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk_result("reset");
        @(negedge clk);
        rst = 1'b0;

        apply_start(8'h3C, 8'h45);
        follow("d_3c_45", 8'h3C, 8'h45, 1'b0);
        expect_idle("d_3c_45");

        apply_start(8'hFF, 8'h01);
        follow("d_ff_01", 8'hFF, 8'h01, 1'b0);
        expect_idle("d_ff_01");

        apply_start(8'h80, 8'h80);
        follow("d_80_80", 8'h80, 8'h80, 1'b0);
        expect_idle("d_80_80");

        apply_start(8'h5A, 8'h7F);
        follow("hold", 8'h5A, 8'h7F, 1'b1);
        done_seen = 0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("hold.extra_done", 32'(done_seen), 32'd0);
        chk_result("hold.after");

        // Abort at bit 4: edge 1 captures, four RUN edges have processed bits 0..3.
        apply_start(8'hA5, 8'h3E);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_sum = '0;
        exp_c   = 1'b0;
        exp_o   = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk_result("abort");
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (W + 3) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("abort.no_done", 32'(done_seen), 32'd0);

        apply_start(8'h01, 8'h02);
        follow("post_abort", 8'h01, 8'h02, 1'b0);

        // Back-to-back: new start during the DONE cycle.
        apply_start(8'h10, 8'h20);
        follow("b2b", 8'h10, 8'h20, 1'b0);
        expect_idle("b2b");

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            apply_start(ra, rb);
            follow("rand", ra, rb, (i % 7) == 3);
            if ((i % 4) != 1) expect_idle("rand");
        end
        expect_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  augend, captured on accepted start.
REQ-006 b  input  WIDTH  addend, captured on accepted start.
REQ-007 busy  output  1  high while an addition is in progress.
REQ-008 done  output  1  one-cycle pulse marking sum/carry_out valid.
REQ-009 sum  output  WIDTH  registered result (a+b) mod 2^WIDTH.
REQ-010 carry_out  output  1  registered carry out of bit WIDTH-1.
REQ-011 overflow  output  1  signed overflow flag; present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at a rising edge SHALL capture a and b into shift registers, clear the carry flop and the bit counter, and enter RUN.
REQ-014 In RUN, each edge SHALL add the operand LSBs and the carry flop, shift the sum bit into the partial-result MSB, store the new carry, shift both operands right and increment the counter.
REQ-015 After exactly WIDTH RUN edges, the FSM SHALL load sum, carry_out (and overflow) from the partial result and carry, and enter DONE.
REQ-016 Latency: with start sampled at edge 1, done SHALL be high during the cycle following edge WIDTH+1, for exactly one cycle.
REQ-017 busy SHALL equal 1 in RUN and 0 in IDLE and DONE.
REQ-018 DONE SHALL return to IDLE on the next edge; start=1 in DONE SHALL be accepted as in IDLE (back-to-back, one idle-free cycle).
REQ-019 start during RUN SHALL be ignored; a and b changes during RUN SHALL not affect the result.
REQ-020 sum, carry_out and overflow SHALL hold their previous values throughout RUN and change only at the DONE transition.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH; carry_out is bit WIDTH of the exact sum.

Reset
REQ-022 rst=1 SHALL immediately force IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, and clear internal registers.
REQ-023 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow for the aborted operation.

Configuration
REQ-024 With SERIAL_ADDER_OVF_EN defined, overflow SHALL be the registered XOR of the carry into and carry out of bit WIDTH-1 for the completed operation.
REQ-025 Without SERIAL_ADDER_OVF_EN, the overflow port and its logic SHALL not exist; all other behaviour is unchanged.

Structure
REQ-026 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-027 A combinational sub-module full_adder (a, b, cin -> s, cout) SHALL implement the per-bit cell, instanced once.

Verification (WIDTH=8)
REQ-028 a=0x3C, b=0x45, start pulse -> done at cycle 9 after start edge, sum=0x81, carry_out=0, overflow=1.
REQ-029 a=0xFF, b=0x01 -> sum=0x00, carry_out=1, overflow=0; a=0x80, b=0x80 -> sum=0x00, carry_out=1, overflow=1.
REQ-030 start held high and a/b changed during RUN -> single result for the originally captured operands; no extra done.
REQ-031 rst pulsed at RUN bit 4 -> all outputs 0 immediately, no done; a subsequent start 0x01+0x02 -> sum=0x03.
REQ-032 start asserted in DONE cycle with new operands 0x10+0x20 -> accepted, sum=0x30 after WIDTH+1 further edges; previous result held until then.
